// File: rtl/cam_pwr_seq_pkg.sv
// Shared types and constants for the camera power/bring-up sequencer.
//   cam_seq_state_t : FSM state encoding, also exported on the debug state port
//   seq_tick_cnt_t  : 20-bit strobe tick counter
//   retry_cnt_t     : failed-init attempt counter
//   cam_seq_out_t   : registered level outputs, decoded from the FSM state
package cam_pwr_seq_pkg;

    localparam int unsigned TICK_CNT_W = 20;
    localparam int unsigned RETRY_W    = 2;
    localparam int unsigned STATE_W    = 3;

    // Default delays in 400kHz strobe ticks
    localparam int unsigned DEF_PWR_DLY_TICKS  = 800;     // 2ms
    localparam int unsigned DEF_I2C_DLY_TICKS  = 400;     // 1ms
    localparam int unsigned DEF_INIT_TMO_TICKS = 400000;  // 1s
    localparam int unsigned DEF_OFF_DLY_TICKS  = 4000;    // 10ms
    localparam int unsigned DEF_MAX_RETRY      = 3;

    typedef enum logic [STATE_W-1:0] {
        OFF      = 3'd0,
        PWR_UP   = 3'd1,
        I2C_RST  = 3'd2,
        CAM_INIT = 3'd3,
        STREAM   = 3'd4,
        PWR_DOWN = 3'd5,
        FAULT    = 3'd6
    } cam_seq_state_t;

    typedef logic [TICK_CNT_W-1:0] seq_tick_cnt_t;
    typedef logic [RETRY_W-1:0]    retry_cnt_t;

    typedef struct packed {
        logic cam_en;
        logic i2c_areset_n;
        logic isp_rst;
        logic ready;
        logic fault;
    } cam_seq_out_t;

    // Everything off / held in reset
    localparam cam_seq_out_t SEQ_OUT_OFF = '{
        cam_en:       1'b0,
        i2c_areset_n: 1'b0,
        isp_rst:      1'b1,
        ready:        1'b0,
        fault:        1'b0
    };

    // Level outputs owned by each state
    function automatic cam_seq_out_t state_outputs(input cam_seq_state_t st);
        cam_seq_out_t o;
        o = SEQ_OUT_OFF;
        case (st)
            PWR_UP, I2C_RST: begin
                o.cam_en = 1'b1;
            end
            CAM_INIT: begin
                o.cam_en       = 1'b1;
                o.i2c_areset_n = 1'b1;
            end
            STREAM: begin
                o.cam_en       = 1'b1;
                o.i2c_areset_n = 1'b1;
                o.isp_rst      = 1'b0;
                o.ready        = 1'b1;
            end
            FAULT: begin
                o.fault = 1'b1;
            end
            default: begin
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cam_pwr_seq_if.sv
// Control/status bundle between the power sequencer and its environment.
//   master : the sequencer (consumes strobe/enable/restart/i2c_*, drives power, reset and status)
//   slave  : the environment (clock/reset generator, I2C master, ISP pipeline)
interface cam_pwr_seq_if;

    logic                          strobe_400kHz;
    logic                          enable;
    logic                          restart;
    logic                          i2c_done;
    logic                          i2c_err;
    logic                          cam_en;
    logic                          i2c_areset_n;
    logic                          init_start;
    logic                          isp_rst;
    logic                          ready;
    logic                          fault;
    cam_pwr_seq_pkg::retry_cnt_t   retry_cnt;
    logic [cam_pwr_seq_pkg::STATE_W-1:0] state;

    modport master (
        input  strobe_400kHz, enable, restart, i2c_done, i2c_err,
        output cam_en, i2c_areset_n, init_start, isp_rst, ready, fault, retry_cnt, state
    );

    modport slave (
        output strobe_400kHz, enable, restart, i2c_done, i2c_err,
        input  cam_en, i2c_areset_n, init_start, isp_rst, ready, fault, retry_cnt, state
    );

endinterface

// File: rtl/cam_pwr_seq.sv
// Camera power/bring-up sequencer on the 400kHz strobe, clk_100 domain.
// Power-up delay, I2C reset hold, handshaked camera init with timeout and
// bounded retries, ISP datapath reset released only while streaming.
//   clk   : 100MHz system clock
//   reset : asynchronous active-high reset
//   bus   : cam_pwr_seq_if.master (strobe/enable/restart/i2c_* in; power, resets, status out)
module cam_pwr_seq
    import cam_pwr_seq_pkg::*;
#(
    parameter int unsigned PWR_DLY_TICKS  = DEF_PWR_DLY_TICKS,
    parameter int unsigned I2C_DLY_TICKS  = DEF_I2C_DLY_TICKS,
    parameter int unsigned INIT_TMO_TICKS = DEF_INIT_TMO_TICKS,
    parameter int unsigned OFF_DLY_TICKS  = DEF_OFF_DLY_TICKS,
    parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic          clk,
    input  logic          reset,
    cam_pwr_seq_if.master bus
);

    // Count value seen on the final tick of each delay
    localparam seq_tick_cnt_t PWR_LAST = seq_tick_cnt_t'(PWR_DLY_TICKS - 1);
    localparam seq_tick_cnt_t I2C_LAST = seq_tick_cnt_t'(I2C_DLY_TICKS - 1);
    localparam seq_tick_cnt_t TMO_LAST = seq_tick_cnt_t'(INIT_TMO_TICKS - 1);
    localparam seq_tick_cnt_t OFF_LAST = seq_tick_cnt_t'(OFF_DLY_TICKS - 1);
    localparam retry_cnt_t    RETRY_LIMIT = retry_cnt_t'(MAX_RETRY);

    cam_seq_state_t state_q, state_d;
    seq_tick_cnt_t  cnt_q, cnt_d;
    retry_cnt_t     retry_q, retry_d;
    cam_seq_out_t   out_q;
    logic           init_start_q;

    logic       pwr_exp_c, i2c_exp_c, tmo_exp_c, off_exp_c;
    logic       init_fail_c;
    retry_cnt_t retry_inc_c;

    // Delay expiry: the tick that completes N ticks in the current state
    assign pwr_exp_c = bus.strobe_400kHz && (cnt_q == PWR_LAST);
    assign i2c_exp_c = bus.strobe_400kHz && (cnt_q == I2C_LAST);
    assign tmo_exp_c = bus.strobe_400kHz && (cnt_q == TMO_LAST);
    assign off_exp_c = bus.strobe_400kHz && (cnt_q == OFF_LAST);

    // Error beats done; done beats timeout
    assign init_fail_c = bus.i2c_err || (!bus.i2c_done && tmo_exp_c);
    assign retry_inc_c = retry_q + retry_cnt_t'(1);

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;

        case (state_q)
            OFF: begin
                if (bus.enable) state_d = PWR_UP;
            end
            PWR_UP: begin
                if (!bus.enable)    state_d = PWR_DOWN;
                else if (pwr_exp_c) state_d = I2C_RST;
            end
            I2C_RST: begin
                if (!bus.enable)    state_d = PWR_DOWN;
                else if (i2c_exp_c) state_d = CAM_INIT;
            end
            CAM_INIT: begin
                if (init_fail_c) begin
                    retry_d = retry_inc_c;
                    state_d = (retry_inc_c == RETRY_LIMIT) ? FAULT : PWR_DOWN;
                end else if (bus.i2c_done) begin
                    retry_d = '0;
                    state_d = STREAM;
                end else if (!bus.enable) begin
                    state_d = PWR_DOWN;
                end
            end
            STREAM: begin
                if (bus.restart || !bus.enable) state_d = PWR_DOWN;
            end
            PWR_DOWN: begin
                if (off_exp_c) state_d = OFF;
            end
            FAULT: begin
                if (!bus.enable) begin
                    retry_d = '0;
                    state_d = OFF;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase

        // Fresh count per state; a tick during the first cycle of a state is its first tick
        if (state_d != state_q)     cnt_d = '0;
        else if (bus.strobe_400kHz) cnt_d = cnt_q + seq_tick_cnt_t'(1);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= OFF;
            cnt_q        <= '0;
            retry_q      <= '0;
            out_q        <= SEQ_OUT_OFF;
            init_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            out_q        <= state_outputs(state_d);
            init_start_q <= (state_d == CAM_INIT) && (state_q != CAM_INIT);
        end
    end

    assign bus.cam_en       = out_q.cam_en;
    assign bus.i2c_areset_n = out_q.i2c_areset_n;
    assign bus.isp_rst      = out_q.isp_rst;
    assign bus.ready        = out_q.ready;
    assign bus.fault        = out_q.fault;
    assign bus.init_start   = init_start_q;
    assign bus.retry_cnt    = retry_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench for cam_pwr_seq with shortened delays and a strobe every 4 clks.
module tb_cam_pwr_seq;
    import cam_pwr_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cam_pwr_seq_if bus();

    cam_pwr_seq #(
        .PWR_DLY_TICKS (4),
        .I2C_DLY_TICKS (2),
        .INIT_TMO_TICKS(10),
        .OFF_DLY_TICKS (3),
        .MAX_RETRY     (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Output vector order: cam_en, i2c_areset_n, init_start, isp_rst, ready, fault
    localparam logic [5:0] O_OFF   = 6'b000100;
    localparam logic [5:0] O_PWR   = 6'b100100;
    localparam logic [5:0] O_INIT1 = 6'b111100;
    localparam logic [5:0] O_STRM  = 6'b110010;
    localparam logic [5:0] O_FAULT = 6'b000101;

    int n_cmp = 0;
    int n_bad = 0;
    int ph    = 0;

    function automatic logic [5:0] outs();
        return {bus.cam_en, bus.i2c_areset_n, bus.init_start, bus.isp_rst, bus.ready, bus.fault};
    endfunction

    // Advance one clk; pulses last exactly one clk, strobe every 4th clk
    task automatic cyc();
        @(posedge clk);
        #1;
        bus.i2c_done      = 1'b0;
        bus.i2c_err       = 1'b0;
        bus.restart       = 1'b0;
        ph                = (ph + 1) % 4;
        bus.strobe_400kHz = (ph == 0);
    endtask

    // Run until target state; ticks = strobes applied outside OFF and target
    task automatic wait_state(input cam_seq_state_t target, input int budget,
                              output bit ok, output int ticks);
        ok    = 1'b0;
        ticks = 0;
        for (int i = 0; i < budget; i++) begin
            if (bus.state == target) begin
                ok = 1'b1;
                break;
            end
            if (bus.strobe_400kHz && bus.state != OFF) ticks++;
            cyc();
        end
        if (!ok && bus.state == target) ok = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.strobe_400kHz = 1'b0; bus.enable = 1'b0; bus.restart = 1'b0;
        bus.i2c_done = 1'b0; bus.i2c_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        n_cmp++; if (outs() !== O_OFF) begin n_bad++; $display("FAIL reset_outs: got %b want %b", outs(), O_OFF); end
        n_cmp++; if (bus.retry_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_retry: got %0d want 0", bus.retry_cnt); end
        reset = 1'b0;
        ph = 0;
        cyc(); cyc();
        n_cmp++; if (bus.state !== OFF) begin n_bad++; $display("FAIL idle_off: got %0d want %0d", bus.state, OFF); end
    endtask

    task automatic test_nominal();
        bit ok; int t; int starts;
        bus.enable = 1'b1;
        cyc();
        n_cmp++; if (bus.state !== PWR_UP || outs() !== O_PWR) begin n_bad++; $display("FAIL nom_pwr_up: got st=%0d o=%b want st=1 o=%b", bus.state, outs(), O_PWR); end
        wait_state(CAM_INIT, 200, ok, t);
        n_cmp++; if (!ok || t != 6) begin n_bad++; $display("FAIL nom_i2c_release: got ok=%0d ticks=%0d want ok=1 ticks=6", ok, t); end
        n_cmp++; if (outs() !== O_INIT1) begin n_bad++; $display("FAIL nom_init_entry: got %b want %b", outs(), O_INIT1); end
        starts = 1;
        t = 0;
        for (int i = 0; i < 200 && t < 5; i++) begin
            if (bus.strobe_400kHz) t++;
            cyc();
            if (bus.init_start) starts++;
        end
        n_cmp++; if (starts != 1 || bus.state !== CAM_INIT) begin n_bad++; $display("FAIL nom_one_start: got starts=%0d st=%0d want 1 st=3", starts, bus.state); end
        bus.i2c_done = 1'b1;
        cyc();
        n_cmp++; if (bus.state !== STREAM || outs() !== O_STRM) begin n_bad++; $display("FAIL nom_stream: got st=%0d o=%b want st=4 o=%b", bus.state, outs(), O_STRM); end
        n_cmp++; if (bus.retry_cnt !== 2'd0) begin n_bad++; $display("FAIL nom_retry: got %0d want 0", bus.retry_cnt); end
    endtask

    task automatic test_restart();
        bit ok; int t; int starts;
        bus.restart = 1'b1;
        cyc();
        n_cmp++; if (bus.state !== PWR_DOWN || outs() !== O_OFF) begin n_bad++; $display("FAIL rst_pwr_down: got st=%0d o=%b want st=5 o=%b", bus.state, outs(), O_OFF); end
        wait_state(OFF, 200, ok, t);
        n_cmp++; if (!ok || t != 3) begin n_bad++; $display("FAIL rst_off_delay: got ok=%0d ticks=%0d want ok=1 ticks=3", ok, t); end
        wait_state(CAM_INIT, 200, ok, t);
        n_cmp++; if (!ok || t != 6) begin n_bad++; $display("FAIL rst_reseq: got ok=%0d ticks=%0d want ok=1 ticks=6", ok, t); end
        starts = bus.init_start ? 1 : 0;
        repeat (12) begin
            cyc();
            if (bus.init_start) starts++;
        end
        n_cmp++; if (starts != 1) begin n_bad++; $display("FAIL rst_one_start: got %0d want 1", starts); end
        bus.i2c_done = 1'b1;
        cyc();
        n_cmp++; if (bus.state !== STREAM) begin n_bad++; $display("FAIL rst_stream: got %0d want 4", bus.state); end
    endtask

    task automatic test_priority();
        bit ok; int t;
        bus.enable = 1'b0;
        cyc();
        n_cmp++; if (bus.state !== PWR_DOWN || bus.retry_cnt !== 2'd0) begin n_bad++; $display("FAIL pri_disable: got st=%0d r=%0d want st=5 r=0", bus.state, bus.retry_cnt); end
        bus.enable = 1'b1;
        wait_state(OFF, 200, ok, t);
        n_cmp++; if (!ok || t != 3) begin n_bad++; $display("FAIL pri_pd_ignores_en: got ok=%0d ticks=%0d want ok=1 ticks=3", ok, t); end
        wait_state(CAM_INIT, 200, ok, t);
        bus.i2c_err = 1'b1;
        bus.i2c_done = 1'b1;
        cyc();
        n_cmp++; if (bus.state !== PWR_DOWN || bus.retry_cnt !== 2'd1) begin n_bad++; $display("FAIL pri_err_wins: got st=%0d r=%0d want st=5 r=1", bus.state, bus.retry_cnt); end
        wait_state(OFF, 200, ok, t);
        wait_state(CAM_INIT, 200, ok, t);
        t = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.strobe_400kHz && t == 9) break;
            if (bus.strobe_400kHz) t++;
            cyc();
        end
        n_cmp++; if (bus.state !== CAM_INIT || t != 9) begin n_bad++; $display("FAIL pri_pre_tmo: got st=%0d ticks=%0d want st=3 ticks=9", bus.state, t); end
        bus.i2c_done = 1'b1;
        cyc();
        n_cmp++; if (bus.state !== STREAM || bus.retry_cnt !== 2'd0) begin n_bad++; $display("FAIL pri_done_on_tmo: got st=%0d r=%0d want st=4 r=0", bus.state, bus.retry_cnt); end
    endtask

    task automatic test_timeout_retry();
        bit ok; int t;
        bus.enable = 1'b0;
        cyc();
        bus.enable = 1'b1;
        wait_state(OFF, 200, ok, t);
        wait_state(CAM_INIT, 200, ok, t);
        wait_state(PWR_DOWN, 200, ok, t);
        n_cmp++; if (!ok || t != 10) begin n_bad++; $display("FAIL tmo_first: got ok=%0d ticks=%0d want ok=1 ticks=10", ok, t); end
        n_cmp++; if (bus.retry_cnt !== 2'd1 || outs() !== O_OFF) begin n_bad++; $display("FAIL tmo_first_outs: got r=%0d o=%b want r=1 o=%b", bus.retry_cnt, outs(), O_OFF); end
        bus.i2c_done = 1'b1;
        cyc();
        n_cmp++; if (bus.state !== PWR_DOWN) begin n_bad++; $display("FAIL tmo_done_ignored: got %0d want 5", bus.state); end
        wait_state(OFF, 200, ok, t);
        wait_state(CAM_INIT, 200, ok, t);
        wait_state(FAULT, 200, ok, t);
        n_cmp++; if (!ok || t != 10) begin n_bad++; $display("FAIL tmo_second: got ok=%0d ticks=%0d want ok=1 ticks=10", ok, t); end
        n_cmp++; if (outs() !== O_FAULT || bus.retry_cnt !== 2'd2) begin n_bad++; $display("FAIL tmo_fault: got o=%b r=%0d want o=%b r=2", outs(), bus.retry_cnt, O_FAULT); end
    endtask

    task automatic test_fault_clear();
        bit ok; int t;
        t = 0;
        for (int i = 0; i < 400 && t < 50; i++) begin
            if (bus.strobe_400kHz) t++;
            cyc();
        end
        n_cmp++; if (bus.state !== FAULT || bus.fault !== 1'b1) begin n_bad++; $display("FAIL fc_hold: got st=%0d f=%b want st=6 f=1", bus.state, bus.fault); end
        bus.enable = 1'b0;
        cyc();
        n_cmp++; if (bus.state !== OFF || outs() !== O_OFF || bus.retry_cnt !== 2'd0) begin n_bad++; $display("FAIL fc_clear: got st=%0d o=%b r=%0d want st=0 o=%b r=0", bus.state, outs(), bus.retry_cnt, O_OFF); end
        bus.enable = 1'b1;
        cyc();
        n_cmp++; if (bus.state !== PWR_UP) begin n_bad++; $display("FAIL fc_reenable: got %0d want 1", bus.state); end
        bus.enable = 1'b0;
        cyc();
        n_cmp++; if (bus.state !== PWR_DOWN || bus.cam_en !== 1'b0) begin n_bad++; $display("FAIL fc_drop_in_pwr_up: got st=%0d en=%b want st=5 en=0", bus.state, bus.cam_en); end
        bus.enable = 1'b1;
        wait_state(OFF, 200, ok, t);
        wait_state(CAM_INIT, 200, ok, t);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fc_reach_init: got ok=%0d want 1", ok); end
    endtask

    task automatic test_async_reset();
        bit ok; int t;
        bus.i2c_err = 1'b1;
        cyc();
        n_cmp++; if (bus.retry_cnt !== 2'd1) begin n_bad++; $display("FAIL ar_err_retry: got %0d want 1", bus.retry_cnt); end
        wait_state(OFF, 200, ok, t);
        wait_state(CAM_INIT, 200, ok, t);
        repeat (3) cyc();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.state !== OFF || outs() !== O_OFF || bus.retry_cnt !== 2'd0) begin n_bad++; $display("FAIL ar_immediate: got st=%0d o=%b r=%0d want st=0 o=%b r=0", bus.state, outs(), bus.retry_cnt, O_OFF); end
        cyc();
        reset = 1'b0;
        cyc();
        n_cmp++; if (bus.state !== PWR_UP) begin n_bad++; $display("FAIL ar_restart: got %0d want 1", bus.state); end
        wait_state(CAM_INIT, 200, ok, t);
        n_cmp++; if (!ok || t != 6) begin n_bad++; $display("FAIL ar_reseq: got ok=%0d ticks=%0d want ok=1 ticks=6", ok, t); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_restart();
        test_priority();
        test_timeout_retry();
        test_fault_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of run, want finish before 2ms");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cam_pwr_seq.md
Name: cam_pwr_seq

Overview:
- Camera power/bring-up sequencer driven by the 400kHz strobe.
- Replaces fixed-time cam_en / i2c_areset_n release with a handshaked FSM: power-up delay, I2C reset hold, camera-init handshake with timeout, bounded retries, and an ISP datapath reset gated on successful init.
- Sits between the clock/reset generator and the I2C master / CSI-ISP pipeline, in the clk_100 domain.

Parameters:
- PWR_DLY_TICKS, 800: strobe ticks cam_en is high before I2C release (2ms).
- I2C_DLY_TICKS, 400: further ticks I2C is held in reset after power-up (1ms).
- INIT_TMO_TICKS, 400000: max ticks waiting for i2c_done (1s).
- OFF_DLY_TICKS, 4000: ticks all outputs are held off during power-down (10ms).
- MAX_RETRY, 3: failed init attempts allowed before FAULT.

Ports:
- clk  in  1  100MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- strobe_400kHz  in  1  one-clk tick, synchronous to clk.
- enable  in  1  level; 1 = camera wanted on.
- restart  in  1  one-clk pulse; forces a power cycle from STREAM.
- i2c_done  in  1  one-clk pulse from I2C master: init sequence complete.
- i2c_err  in  1  one-clk pulse from I2C master: NACK/bus error.
- cam_en  out  1  camera power/enable pin.
- i2c_areset_n  out  1  I2C master reset, active-low.
- init_start  out  1  one-clk pulse: start camera register init.
- isp_rst  out  1  CSI/ISP datapath reset, active-high.
- ready  out  1  camera streaming.
- fault  out  1  retries exhausted.
- retry_cnt  out  2  failed attempts in current bring-up.
- state  out  3  current FSM state, for debug/ILA.

Behaviour:
- All outputs registered. Reset values: state=OFF, cam_en=0, i2c_areset_n=0, init_start=0, isp_rst=1, ready=0, fault=0, retry_cnt=0, tick counter=0.
- Tick counter is 20 bits. It clears on every state entry and increments only on strobe_400kHz. A delay of N expires on the tick that makes count==N-1, and the transition happens on that clk.
- OFF: all outputs at reset values. If enable=1, go to PWR_UP on the next clk.
- PWR_UP: cam_en=1. After PWR_DLY_TICKS, go to I2C_RST.
- I2C_RST: cam_en=1, i2c_areset_n=0. After I2C_DLY_TICKS, go to CAM_INIT.
- CAM_INIT:
  - i2c_areset_n=1; init_start pulses exactly one clk, on the first clk in the state.
  - Event priority: i2c_err > i2c_done > timeout > enable=0.
  - i2c_done → STREAM, retry_cnt cleared.
  - i2c_err or timeout (INIT_TMO_TICKS expired) → retry_cnt+1. If the new value == MAX_RETRY go to FAULT, else go to PWR_DOWN.
  - enable=0 → PWR_DOWN, retry_cnt unchanged.
- STREAM: cam_en=1, i2c_areset_n=1, isp_rst=0, ready=1. restart=1 or enable=0 → PWR_DOWN, retry_cnt unchanged.
- PWR_DOWN: cam_en=0, i2c_areset_n=0, isp_rst=1, ready=0. After OFF_DLY_TICKS, go to OFF. Ignores enable, restart, i2c_* while here.
- FAULT: as PWR_DOWN outputs plus fault=1. Stays until enable=0, then goes to OFF and clears retry_cnt and fault.
- Ticks arriving in the same clk as a state entry count toward the new state (counter starts at 0 and counts that tick).
- enable dropping in PWR_UP or I2C_RST → PWR_DOWN immediately.
- i2c_done / i2c_err outside CAM_INIT are ignored.
- Asserting reset mid-sequence returns immediately to reset values; there is no power-down delay on reset.

Decomposition:
- top_pkg additions:
  - cam_seq_state_t enum: OFF=0, PWR_UP=1, I2C_RST=2, CAM_INIT=3, STREAM=4, PWR_DOWN=5, FAULT=6.
  - seq_tick_cnt_t: logic[19:0].
  - Default tick constants for the parameters above.
- No sub-module; the counter and FSM live in one always_ff pair plus output decode.

Test Plan:
- Sim params for all cases: PWR_DLY=4, I2C_DLY=2, INIT_TMO=10, OFF_DLY=3, MAX_RETRY=2; strobe every 4 clks.
- Nominal: enable=1, i2c_done 5 ticks into CAM_INIT → cam_en rises 1 clk after enable; i2c_areset_n rises after 6 ticks; one init_start pulse; ready=1 and isp_rst=0 the clk after done; retry_cnt=0.
- Timeout retry: no i2c_done → PWR_DOWN after 10 ticks with retry_cnt=1; 3 ticks off; second bring-up; second timeout → FAULT with fault=1, retry_cnt=2, cam_en=0.
- Fault clear: in FAULT, hold enable=1 for 50 ticks → stays FAULT. Drop enable → OFF with fault=0, retry_cnt=0. Re-enable → PWR_UP.
- Priority: i2c_err and i2c_done in same clk → treated as error, retry_cnt=1, state PWR_DOWN. i2c_done on the timeout tick → STREAM.
- Restart: restart pulse in STREAM → ready=0, cam_en=0 next clk; 3 ticks later OFF, then full re-sequence with a single new init_start.
- Async reset mid-CAM_INIT: assert reset between edges → outputs return to reset values without waiting for clk; after release, sequence restarts from OFF.
